// File: rtl/tpm_fifo_stream_tracker_if.sv
// tpm_fifo_stream_tracker_if: SPI byte-exchange handshake feeding the TPM FIFO stream tracker.
interface tpm_fifo_stream_tracker_if #(
  parameter int NUM_DATA_BITS = 8
);
  logic                     frame_active;
  logic                     byte_valid;
  logic [NUM_DATA_BITS-1:0] mosi_byte;
  logic [NUM_DATA_BITS-1:0] miso_byte;
  modport master (output frame_active, byte_valid, mosi_byte, miso_byte);
  modport slave  (input  frame_active, byte_valid, mosi_byte, miso_byte);
endinterface

// File: rtl/tpm_fifo_stream_tracker.sv
// tpm_fifo_stream_tracker: decodes TPM SPI frames and tracks command/response streams on the FIFO register.
module tpm_fifo_stream_tracker #(
  parameter int          NUM_DATA_BITS  = 8,
  parameter logic [23:0] FIFO_ADDR      = 24'hD40024,
  parameter int          MAX_XFER_BYTES = 64,
  parameter int          LEN_WIDTH      = 12
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  tpm_fifo_stream_tracker_if.slave bus,
  output logic                     hdr_valid,
  output logic                     xfer_is_read,
  output logic [6:0]               xfer_size,
  output logic [23:0]              xfer_addr,
  output logic                     addr_match,
  output logic                     data_valid,
  output logic [NUM_DATA_BITS-1:0] data_byte,
  output logic [5:0]               data_index,
  output logic [LEN_WIDTH-1:0]     stream_offset,
  output logic [LEN_WIDTH-1:0]     stream_len,
  output logic                     stream_is_read,
  output logic                     payload_valid,
  output logic                     stream_done,
  output logic                     proto_err
);
  typedef enum logic [2:0] {IDLE, HDR, ADDR_HI, ADDR_MID, ADDR_LO, WAIT, DATA, DONE} state_t;
  typedef struct packed {
    logic                     hdr_valid;
    logic                     xfer_is_read;
    logic [6:0]               xfer_size;
    logic [23:0]              xfer_addr;
    logic                     addr_match;
    logic                     data_valid;
    logic [NUM_DATA_BITS-1:0] data_byte;
    logic [5:0]               data_index;
    logic [LEN_WIDTH-1:0]     stream_offset;
    logic [LEN_WIDTH-1:0]     stream_len;
    logic                     stream_is_read;
    logic                     payload_valid;
    logic                     stream_done;
    logic                     proto_err;
  } out_t;
  localparam logic [6:0] MAX_SZ = 7'(MAX_XFER_BYTES);
  state_t                   state_q, state_d, st_byte;
  out_t                     o_q, o_d;
  logic                     sync_q, sync_d, done_err_q, done_err_d;
  logic [6:0]               cnt_q, cnt_d, size_raw;
  logic [23:0]              sh_q, sh_d;
  logic [31:0]              full_len;
  logic [NUM_DATA_BITS-1:0] byte_w;
  logic                     last, abort, len_bad, rd_mismatch;
  assign size_raw    = {1'b0, bus.mosi_byte[5:0]} + 7'd1;
  assign last        = cnt_q == o_q.xfer_size - 7'd1;
  assign byte_w      = o_q.xfer_is_read ? bus.miso_byte : bus.mosi_byte;
  assign full_len    = {sh_q, byte_w};
  assign len_bad     = (full_len >> LEN_WIDTH) != 32'd0 || full_len < 32'd10;
  assign rd_mismatch = o_q.stream_offset != '0 && o_q.xfer_is_read != o_q.stream_is_read;
  // a byte coincident with frame end is applied first, so completing the last data byte is not an abort
  assign abort       = state_q != IDLE && !bus.frame_active && st_byte != DONE;
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    st_byte = state_q;
    if (bus.byte_valid)
      case (state_q)
        HDR:           st_byte = ADDR_HI;
        ADDR_HI:       st_byte = ADDR_MID;
        ADDR_MID:      st_byte = ADDR_LO;
        ADDR_LO, WAIT: st_byte = bus.miso_byte[0] ? DATA : WAIT;
        DATA:          st_byte = last ? DONE : DATA;
        default:       st_byte = state_q;
      endcase
    state_d = st_byte;
    // sync_q holds off frame starts until slave-select has been seen idle after reset
    if (state_q == IDLE) state_d = (bus.frame_active && sync_q) ? HDR : IDLE;
    else if (!bus.frame_active) state_d = IDLE;
  end
  always_comb begin
    o_d               = o_q;
    o_d.hdr_valid     = 1'b0;
    o_d.data_valid    = 1'b0;
    o_d.payload_valid = 1'b0;
    o_d.stream_done   = 1'b0;
    o_d.proto_err     = 1'b0;
    sync_d            = sync_q | ~bus.frame_active;
    done_err_d        = done_err_q;
    cnt_d             = cnt_q;
    sh_d              = sh_q;
    if (state_q == IDLE && state_d == HDR) begin
      done_err_d     = 1'b0;
      o_d.addr_match = 1'b0;
      cnt_d          = '0;
    end
    if (bus.byte_valid)
      case (state_q)
        HDR: begin
          o_d.xfer_is_read = bus.mosi_byte[7];
          o_d.xfer_size    = size_raw > MAX_SZ ? MAX_SZ : size_raw;
        end
        ADDR_HI:  o_d.xfer_addr[23:16] = bus.mosi_byte;
        ADDR_MID: o_d.xfer_addr[15:8]  = bus.mosi_byte;
        ADDR_LO: begin
          o_d.xfer_addr[7:0] = bus.mosi_byte;
          o_d.hdr_valid      = 1'b1;
          o_d.addr_match     = {o_q.xfer_addr[23:8], bus.mosi_byte} == FIFO_ADDR;
        end
        DATA: begin
          o_d.data_valid = 1'b1;
          o_d.data_byte  = byte_w;
          o_d.data_index = cnt_q[5:0];
          cnt_d          = cnt_q + 7'd1;
          if (o_q.addr_match && rd_mismatch) begin
            o_d.proto_err      = 1'b1;
            o_d.stream_is_read = o_q.xfer_is_read;
            o_d.stream_offset  = LEN_WIDTH'(1);
            o_d.stream_len     = '0;
          end else if (o_q.addr_match) begin
            if (o_q.stream_offset == '0) o_d.stream_is_read = o_q.xfer_is_read;
            o_d.stream_offset = o_q.stream_offset + LEN_WIDTH'(1);
            if (o_q.stream_offset >= LEN_WIDTH'(2) && o_q.stream_offset <= LEN_WIDTH'(4)) sh_d = {sh_q[15:0], byte_w};
            if (o_q.stream_offset == LEN_WIDTH'(5)) begin
              o_d.proto_err     = len_bad;
              o_d.stream_len    = len_bad ? '0 : full_len[LEN_WIDTH-1:0];
              o_d.stream_offset = len_bad ? '0 : LEN_WIDTH'(6);
            end
            o_d.payload_valid = o_q.stream_offset >= LEN_WIDTH'(10);
            if (o_q.stream_len != '0 && o_q.stream_offset == o_q.stream_len - LEN_WIDTH'(1)) begin
              o_d.stream_done   = 1'b1;
              o_d.stream_offset = '0;
              o_d.stream_len    = '0;
            end
          end
        end
        DONE: begin
          o_d.proto_err = ~done_err_q;
          done_err_d    = 1'b1;
        end
        default: ;
      endcase
    if (state_q != IDLE && !bus.frame_active) o_d.addr_match = 1'b0;
    if (abort) begin
      o_d.proto_err      = 1'b1;
      o_d.stream_offset  = '0;
      o_d.stream_len     = '0;
      o_d.stream_is_read = 1'b0;
    end
  end
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      o_q        <= '0;
      sync_q     <= 1'b0;
      done_err_q <= 1'b0;
      cnt_q      <= '0;
      sh_q       <= '0;
    end else begin
      o_q        <= o_d;
      sync_q     <= sync_d;
      done_err_q <= done_err_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
    end
  assign hdr_valid      = o_q.hdr_valid;
  assign xfer_is_read   = o_q.xfer_is_read;
  assign xfer_size      = o_q.xfer_size;
  assign xfer_addr      = o_q.xfer_addr;
  assign addr_match     = o_q.addr_match;
  assign data_valid     = o_q.data_valid;
  assign data_byte      = o_q.data_byte;
  assign data_index     = o_q.data_index;
  assign stream_offset  = o_q.stream_offset;
  assign stream_len     = o_q.stream_len;
  assign stream_is_read = o_q.stream_is_read;
  assign payload_valid  = o_q.payload_valid;
  assign stream_done    = o_q.stream_done;
  assign proto_err      = o_q.proto_err;
endmodule

// File: tb/tb_tpm_fifo_stream_tracker.sv
// tb_tpm_fifo_stream_tracker: directed frames against hand-computed TPM stream expectations.
module tb_tpm_fifo_stream_tracker;
  localparam logic [23:0] FIFO = 24'hD40024;
  localparam logic [23:0] OTHER = 24'hD40018;
  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        hdr_valid, xfer_is_read, addr_match, data_valid;
  logic [6:0]  xfer_size;
  logic [23:0] xfer_addr;
  logic [7:0]  data_byte;
  logic [5:0]  data_index;
  logic [11:0] stream_offset, stream_len;
  logic        stream_is_read, payload_valid, stream_done, proto_err;
  logic [76:0] all_o;
  int          n_run = 0, n_fail = 0;
  int          pl, dn, pe, p;
  logic [23:0] h_addr;
  logic [6:0]  h_size;
  logic        h_rd, h_match;
  logic [11:0] off_pre;
  logic [7:0]  mem [32];
  logic [7:0]  cmd [12] = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h01, 8'h7B, 8'h00, 8'h08};
  logic [7:0]  rsp [20] = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h14, 8'h00, 8'h00, 8'h00, 8'h00,
                            8'h00, 8'h08, 8'h4A, 8'h3B, 8'h1C, 8'h21, 8'h01, 8'hA7, 8'hCC, 8'h09};
  tpm_fifo_stream_tracker_if bus ();
  tpm_fifo_stream_tracker dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .bus(bus),
    .hdr_valid(hdr_valid), .xfer_is_read(xfer_is_read), .xfer_size(xfer_size), .xfer_addr(xfer_addr),
    .addr_match(addr_match), .data_valid(data_valid), .data_byte(data_byte), .data_index(data_index),
    .stream_offset(stream_offset), .stream_len(stream_len), .stream_is_read(stream_is_read),
    .payload_valid(payload_valid), .stream_done(stream_done), .proto_err(proto_err)
  );
  assign all_o = {hdr_valid, xfer_is_read, xfer_size, xfer_addr, addr_match, data_valid, data_byte, data_index,
                  stream_offset, stream_len, stream_is_read, payload_valid, stream_done, proto_err};
  always #5 sys_clk = ~sys_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] mo, input logic [7:0] mi);
    @(negedge sys_clk);
    bus.byte_valid = 1'b1;
    bus.mosi_byte  = mo;
    bus.miso_byte  = mi;
    @(posedge sys_clk);
    #1;
    bus.byte_valid = 1'b0;
  endtask
  task automatic clr();
    pl = 0;
    dn = 0;
    pe = 0;
  endtask
  task automatic load_cmd();
    for (int i = 0; i < 12; i++) mem[i] = cmd[i];
    p = 0;
  endtask
  task automatic load_rsp();
    for (int i = 0; i < 20; i++) mem[i] = rsp[i];
    p = 0;
  endtask
  task automatic xfer(input bit rd, input int size, input logic [23:0] addr, input int waits,
                      input int abort_at, input int extra, input bit junk);
    logic [7:0] b;
    @(negedge sys_clk);
    bus.frame_active = 1'b1;
    send({rd, 1'b0, 6'(size - 1)}, 8'h00);
    send(addr[23:16], 8'h00);
    send(addr[15:8], 8'h00);
    send(addr[7:0], {7'd0, waits == 0});
    chk("hdr_valid", 32'(hdr_valid), 1);
    h_addr  = xfer_addr;
    h_size  = xfer_size;
    h_rd    = xfer_is_read;
    h_match = addr_match;
    for (int w = 1; w <= waits; w++) send(8'h00, {7'd0, w == waits});
    for (int i = 0; i < size; i++) begin
      if (i == abort_at) break;
      b = junk ? 8'hEE : mem[p];
      if (!junk) p++;
      send(rd ? 8'h00 : b, rd ? b : 8'h00);
      chk("data_valid", 32'(data_valid), 1);
      chk("data_index", 32'(data_index), i);
      chk("data_byte", 32'(data_byte), 32'(b));
      pl += int'(payload_valid);
      dn += int'(stream_done);
      pe += int'(proto_err);
    end
    for (int e = 0; e < extra; e++) begin
      send(8'h55, 8'h55);
      pe += int'(proto_err);
    end
    off_pre = stream_offset;
    @(negedge sys_clk);
    bus.frame_active = 1'b0;
    @(posedge sys_clk);
    #1;
    pe += int'(proto_err);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0;
    bus.frame_active = 1'b0;
    bus.byte_valid = 1'b0;
    bus.mosi_byte = 8'h00;
    bus.miso_byte = 8'h00;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset_outputs", 32'(|all_o), 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (2) @(posedge sys_clk);
    // GetRandom command written one byte per frame
    load_cmd();
    clr();
    for (int f = 0; f < 12; f++) begin
      xfer(1'b0, 1, FIFO, 0, -1, 0, 1'b0);
      if (f == 0) begin
        chk("w1_addr", 32'(h_addr), 32'hD40024);
        chk("w1_match", 32'(h_match), 1);
        chk("w1_size", 32'(h_size), 1);
        chk("w1_rd", 32'(h_rd), 0);
      end
      if (f == 5) begin
        chk("w1_len", 32'(stream_len), 12);
        chk("w1_off6", 32'(stream_offset), 6);
        chk("w1_sir", 32'(stream_is_read), 0);
      end
      if (f == 10) chk("w1_no_early_done", 32'(dn), 0);
    end
    chk("w1_done", 32'(dn), 1);
    chk("w1_payload", 32'(pl), 2);
    chk("w1_err", 32'(pe), 0);
    chk("w1_off_clr", 32'(stream_offset), 0);
    chk("w1_len_clr", 32'(stream_len), 0);
    // 20-byte response read in size-4 frames with random wait states
    load_rsp();
    clr();
    for (int f = 0; f < 5; f++) begin
      xfer(1'b1, 4, FIFO, int'($urandom_range(0, 2)), -1, 0, 1'b0);
      if (f == 1) begin
        chk("r4_len", 32'(stream_len), 20);
        chk("r4_off8", 32'(stream_offset), 8);
        chk("r4_sir", 32'(stream_is_read), 1);
      end
    end
    chk("r4_payload", 32'(pl), 10);
    chk("r4_done", 32'(dn), 1);
    chk("r4_err", 32'(pe), 0);
    chk("r4_last_byte", 32'(data_byte), 32'h09);
    // header 0x84: size-5 reads
    load_rsp();
    clr();
    for (int f = 0; f < 4; f++) begin
      xfer(1'b1, 5, FIFO, 0, -1, 0, 1'b0);
      if (f == 0) begin
        chk("r5_size", 32'(h_size), 5);
        chk("r5_rd", 32'(h_rd), 1);
      end
    end
    chk("r5_payload", 32'(pl), 10);
    chk("r5_done", 32'(dn), 1);
    chk("r5_err", 32'(pe), 0);
    // non-FIFO frame interleaved mid-stream
    load_cmd();
    clr();
    xfer(1'b0, 4, FIFO, 0, -1, 0, 1'b0);
    chk("il_off4", 32'(stream_offset), 4);
    xfer(1'b0, 4, OTHER, 1, -1, 0, 1'b1);
    chk("il_match", 32'(h_match), 0);
    chk("il_addr", 32'(h_addr), 32'hD40018);
    chk("il_off_kept", 32'(stream_offset), 4);
    xfer(1'b0, 4, FIFO, 0, -1, 0, 1'b0);
    xfer(1'b0, 4, FIFO, 0, -1, 0, 1'b0);
    chk("il_done", 32'(dn), 1);
    chk("il_err", 32'(pe), 0);
    // slave-select dropped after two data bytes
    load_cmd();
    clr();
    xfer(1'b0, 4, FIFO, 0, 2, 0, 1'b0);
    chk("ab_off_pre", 32'(off_pre), 2);
    chk("ab_err", 32'(pe), 1);
    chk("ab_off_clr", 32'(stream_offset), 0);
    chk("ab_match_clr", 32'(addr_match), 0);
    // bytes beyond the transfer size: one error per frame
    clr();
    xfer(1'b0, 1, OTHER, 0, -1, 2, 1'b1);
    chk("done_extra_err", 32'(pe), 1);
    // length field below the minimum, then above the counter range
    mem[0] = 8'h80; mem[1] = 8'h01; mem[2] = 8'h00; mem[3] = 8'h00; mem[4] = 8'h00; mem[5] = 8'h05;
    p = 0;
    clr();
    xfer(1'b0, 6, FIFO, 0, -1, 0, 1'b0);
    chk("len_small_err", 32'(pe), 1);
    chk("len_small_off", 32'(stream_offset), 0);
    chk("len_small_len", 32'(stream_len), 0);
    mem[4] = 8'h10; mem[5] = 8'h00;
    p = 0;
    clr();
    xfer(1'b0, 6, FIFO, 0, -1, 0, 1'b0);
    chk("len_big_err", 32'(pe), 1);
    chk("len_big_off", 32'(stream_offset), 0);
    // direction change mid-stream restarts at offset 0
    mem[0] = 8'h80; mem[1] = 8'h01; mem[2] = 8'h00; mem[3] = 8'h80;
    p = 0;
    clr();
    xfer(1'b0, 3, FIFO, 0, -1, 0, 1'b0);
    chk("dir_off3", 32'(stream_offset), 3);
    xfer(1'b1, 1, FIFO, 0, -1, 0, 1'b0);
    chk("dir_err", 32'(pe), 1);
    chk("dir_sir", 32'(stream_is_read), 1);
    chk("dir_off1", 32'(stream_offset), 1);
    clr();
    xfer(1'b0, 1, FIFO, 0, 0, 0, 1'b0);
    chk("dir_cleanup_err", 32'(pe), 1);
    // asynchronous reset while waiting for the TPM
    load_cmd();
    clr();
    xfer(1'b0, 4, FIFO, 0, -1, 0, 1'b0);
    @(negedge sys_clk);
    bus.frame_active = 1'b1;
    send(8'h03, 8'h00);
    send(8'hD4, 8'h00);
    send(8'h00, 8'h00);
    send(8'h24, 8'h00);
    send(8'h00, 8'h00);
    chk("rw_match_pre", 32'(addr_match), 1);
    chk("rw_off_pre", 32'(stream_offset), 4);
    @(negedge sys_clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rw_reset_outputs", 32'(|all_o), 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    send(8'h00, 8'h01);
    send(8'h11, 8'h22);
    chk("rw_ignored_dv", 32'(data_valid | hdr_valid), 0);
    send(8'h33, 8'h44);
    chk("rw_ignored_dv2", 32'(data_valid | hdr_valid), 0);
    @(negedge sys_clk);
    bus.frame_active = 1'b0;
    @(posedge sys_clk);
    #1;
    chk("rw_no_err", 32'(proto_err), 0);
    load_cmd();
    clr();
    xfer(1'b0, 4, FIFO, 0, -1, 0, 1'b0);
    chk("rw_next_addr", 32'(h_addr), 32'hD40024);
    chk("rw_next_match", 32'(h_match), 1);
    chk("rw_next_off", 32'(stream_offset), 4);
    chk("rw_next_err", 32'(pe), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/tpm_fifo_stream_tracker.md
TPM_FIFO_STREAM_TRACKER -- requirements
Module: tpm_fifo_stream_tracker

Interface
REQ-001 SHALL have parameter NUM_DATA_BITS, default 8, bits per SPI byte (fixed at 8 for TPM framing).
REQ-002 SHALL have parameter FIFO_ADDR, default 24'hD40024, TPM FIFO register address to match.
REQ-003 SHALL have parameter MAX_XFER_BYTES, default 64, largest legal transfer size (1..64).
REQ-004 SHALL have parameter LEN_WIDTH, default 12, width of the stream length and offset counters.
REQ-005 SHALL have port sys_clk, input, 1, the single system clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-007 SHALL have port frame_active, input, 1, SPI slave-select asserted (already synchronised, polarity-normalised).
REQ-008 SHALL have port byte_valid, input, 1, single-cycle strobe: one full SPI byte exchanged.
REQ-009 SHALL have ports mosi_byte and miso_byte, input, 8 each, the bytes exchanged, qualified by byte_valid.
REQ-010 SHALL have ports hdr_valid, xfer_is_read, xfer_size[6:0] and xfer_addr[23:0], output; hdr_valid pulses when the header is decoded, xfer_size holds the byte count (header bits[5:0] + 1).
REQ-011 SHALL have port addr_match, output, 1, xfer_addr == FIFO_ADDR, valid from hdr_valid until the frame ends.
REQ-012 SHALL have ports data_valid (1), data_byte (8) and data_index (6), output; data_valid pulses per data-phase byte.
REQ-013 SHALL have ports stream_offset[LEN_WIDTH-1:0], stream_len[LEN_WIDTH-1:0], stream_is_read, payload_valid, stream_done and proto_err, output.

Function
REQ-014 All outputs SHALL be registered; each response SHALL appear on the cycle after the causing byte_valid.
REQ-015 Frame FSM states SHALL be IDLE, HDR, ADDR_HI, ADDR_MID, ADDR_LO, WAIT, DATA and DONE.
REQ-016 IDLE -> HDR SHALL occur on frame_active=1; HDR captures R/W = mosi[7] (1 = read) and size = mosi[5:0] + 1.
REQ-017 ADDR_HI, ADDR_MID and ADDR_LO SHALL capture xfer_addr MSB first; hdr_valid SHALL pulse after ADDR_LO.
REQ-018 At ADDR_LO: miso_byte[0]=1 -> DATA, else -> WAIT; in WAIT, each byte with miso_byte[0]=1 -> DATA, else stay.
REQ-019 In DATA, data_byte SHALL be miso_byte on reads and mosi_byte on writes; data_index counts 0..xfer_size-1; after the last byte -> DONE.
REQ-020 Bytes received in DONE SHALL be ignored; the first one SHALL pulse proto_err once per frame.
REQ-021 frame_active=0 SHALL return any state to IDLE; if it occurs before DONE, proto_err SHALL pulse and the stream SHALL reset.
REQ-022 A byte_valid coincident with frame_active falling SHALL be processed before the frame end is applied.
REQ-023 Only DATA bytes of frames with addr_match=1 SHALL advance the stream tracker; non-matching frames leave it untouched.
REQ-024 Stream tracker: the first byte of a stream latches stream_is_read = xfer_is_read, and stream_offset increments per byte from 0.
REQ-025 Offsets 2..5 SHALL assemble a 32-bit big-endian length; stream_len = low LEN_WIDTH bits.
REQ-026 When offset 5 is consumed: if the upper length bits are nonzero or length < 10, proto_err SHALL pulse and the stream SHALL reset.
REQ-027 payload_valid SHALL accompany data_valid for stream bytes at offset >= 10.
REQ-028 On the byte at offset stream_len-1: stream_done SHALL pulse, and offset and length SHALL clear for the next stream.
REQ-029 A matched byte whose direction differs from stream_is_read mid-stream SHALL pulse proto_err and restart the stream with that byte at offset 0.
REQ-030 Streams SHALL span any number of frames with any transfer sizes; the offset SHALL never wrap because length <= 2^LEN_WIDTH-1 is enforced.

Reset
REQ-031 On rst_n=0 the FSM SHALL enter IDLE and every output and counter SHALL clear to 0 immediately, including mid-frame.
REQ-032 After rst_n release the block SHALL ignore the remainder of any frame already active, resynchronising on the next frame_active rise.

Verification
REQ-033 Write frame to D40024, size 1, 0 waits, 12 frames of GetRandom cmd 80 01 00 00 00 0C 00 00 01 7B 00 08 -> stream_len=12, stream_is_read=0, stream_done on the 12th byte.
REQ-034 Read frames, size 4, 0-2 random waits, 20-byte response ending 4A 3B 1C 21 01 A7 CC 09 -> payload_valid on offsets 10..19, stream_done once.
REQ-035 Size-5 transfers (4 frames), header 0x84 -> xfer_size=5, data_index 0..4 per frame, stream completes correctly.
REQ-036 Frame to address D40018 interleaved mid-stream -> addr_match=0, stream_offset unchanged.
REQ-037 SS deasserted after 2 data bytes of a size-4 transfer -> proto_err pulse, FSM IDLE, stream_offset=0.
REQ-038 rst_n pulsed low during WAIT -> all outputs 0 at once; the next complete frame decodes normally.
